cntr_modulus_down_la: RTL

Modulus down-counter with a registered zero-lookahead flag, for high-fmax dividers and timers. It counts MOD_VAL-1 down to 0, then wraps to MOD_VAL-1. Wrap detection comes from a flag computed one cycle early, so the next-state path holds no wide compare. A registered terminal-count output and a cascade-enable output let instances chain into multi-stage prescalers.

---
 rtl/cntr_modulus_down_la.sv | 63 ++++++
 1 files changed

// File: rtl/cntr_modulus_down_la.sv
// Modulus down-counter (MOD_VAL-1 .. 0) with a registered zero-lookahead flag driving tc.
// Optional build macro CNTR_MOD_DOWN_LOAD_CLAMP_EN clamps sload data >= MOD_VAL to MOD_VAL-1.
module cntr_modulus_down_la #(
  parameter int WIDTH   = 16,
  parameter int MOD_VAL = 50223
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             sclear,
  input  logic             sload,
  input  logic [WIDTH-1:0] sdata,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             cout
);

  // MOD_VAL = 2**WIDTH truncates to all ones, giving a free-running counter.
  localparam logic [WIDTH-1:0] WRAP_VAL = WIDTH'(MOD_VAL - 1);

`ifdef CNTR_MOD_DOWN_LOAD_CLAMP_EN
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MOD_VAL);
`endif

  function automatic logic [WIDTH-1:0] load_value(input logic [WIDTH-1:0] d);
`ifdef CNTR_MOD_DOWN_LOAD_CLAMP_EN
    return ({1'b0, d} >= MOD_EXT) ? WRAP_VAL : d;
`else
    return d;
`endif
  endfunction

  logic             zero_r;
  logic [WIDTH-1:0] load_q;

  assign load_q = load_value(sdata);

  // zero_r is predicted from q==1 so the q next-state mux never compares q against 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= '0;
      zero_r <= 1'b1;
    end else if (ena) begin
      if (sclear) begin
        q      <= '0;
        zero_r <= 1'b1;
      end else if (sload) begin
        q      <= load_q;
        zero_r <= (load_q == '0);
      end else if (zero_r) begin
        q      <= WRAP_VAL;
        zero_r <= 1'b0;
      end else begin
        q      <= q - WIDTH'(1);
        zero_r <= (q == WIDTH'(1));
      end
    end
  end

  assign tc   = zero_r;
  assign cout = zero_r & ena;

endmodule
